// File: rtl/button_pulse_gen.sv
// Push-button debouncer: two-flop synchronizer, stability FSM, one-cycle press strobe.
// Optional auto-repeat while held is enabled by defining BUTTON_PULSE_GEN_AUTO_REPEAT_EN.
module button_pulse_gen #(
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic btn_level
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // Parameters below 2 would make the terminal count collide with the entry value.
    if (STABLE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("button_pulse_gen: STABLE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;
    logic          level_q;

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
    localparam int RCW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RCW-1:0] RCNT_MAX = RCW'(REPEAT_CYCLES - 1);
    logic [RCW-1:0] rcnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt_q  <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    // A release sample wins over a coincident repeat terminal count.
                    if (!sync2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt_q  <= '0;
                    end else if (rcnt_q == RCNT_MAX) begin
                        pulse_q <= 1'b1;
                        rcnt_q  <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt_q  <= '0;
`endif
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse     = pulse_q;
    assign btn_level = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: run-length reference model plus directed literal checks.
module tb_button_pulse_gen;

    localparam int STABLE = 4;
    localparam int REPEAT = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic pulse;
    logic btn_level;

    int n_pass = 0;
    int n_total = 0;
    int pulse_cnt = 0;
    logic cmp_en = 1'b0;
    logic prev_pulse = 1'b0;

    button_pulse_gen #(.STABLE_CYCLES(STABLE), .REPEAT_CYCLES(REPEAT)) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .pulse(pulse), .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: the input reaches the controller two edges late; a level
    // change is accepted after STABLE+1 consecutive differing samples.
    logic [1:0] m_hist = 2'b00;
    logic m_level = 1'b0;
    logic m_pulse = 1'b0;
    logic m_s;
    int   m_run = 0;
    int   m_rep = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hist = 2'b00; m_level = 1'b0; m_pulse = 1'b0; m_run = 0; m_rep = 0;
        end else begin
            m_s = m_hist[1];
            m_pulse = 1'b0;
            if (m_s == m_level) begin
                if (m_level && m_run == 0) begin
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
                    m_rep++;
                    if (m_rep == REPEAT) begin
                        m_pulse = 1'b1;
                        m_rep = 0;
                    end
`endif
                end else begin
                    m_rep = 0;
                end
                m_run = 0;
            end else begin
                m_run++;
                m_rep = 0;
                if (m_run == STABLE + 1) begin
                    m_level = m_s;
                    m_run = 0;
                    if (m_s) m_pulse = 1'b1;
                end
            end
            m_hist = {m_hist[0], btn_in};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pulse", pulse, m_pulse);
            chk("model_level", btn_level, m_level);
            if (prev_pulse) chk("pulse_back_to_back", pulse, 1'b0);
            if (pulse === 1'b1) pulse_cnt++;
            prev_pulse = pulse;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        logic seen;
        logic exp_p;
        int dwell;
        logic bounce [9];
        bounce = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        wait_n(3);
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("reset_pulse", pulse, 1'b0);
        chk("reset_level", btn_level, 1'b0);
        wait_n(2);

        // Clean press: pulse and level rise after edge 6
        btn_in = 1'b1;
        wait_n(6);
        chk("press_e5_pulse", pulse, 1'b0);
        chk("press_e5_level", btn_level, 1'b0);
        wait_n(1);
        chk("press_e6_pulse", pulse, 1'b1);
        chk("press_e6_level", btn_level, 1'b1);
        wait_n(1);
        chk("press_e7_pulse", pulse, 1'b0);
        chk("press_e7_level", btn_level, 1'b1);
        wait_n(12);
        btn_in = 1'b0;
        wait_n(6);
        chk("release_e5_level", btn_level, 1'b1);
        wait_n(1);
        chk("release_e6_level", btn_level, 1'b0);
        wait_n(5);

        // Bounce: 1,0,1,0,1 with 2-cycle dwell then steady high
        base = pulse_cnt;
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            btn_in = bounce[i];
            if (i < 8) begin
                wait_n(1);
                if (btn_level !== 1'b0 || pulse !== 1'b0) seen = 1'b1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            wait_n(1);
            if (btn_level !== 1'b0 || pulse !== 1'b0) seen = 1'b1;
        end
        chk("bounce_quiet", seen, 1'b0);
        wait_n(1);
        chk("bounce_e6_pulse", pulse, 1'b1);
        wait_n(3);
        chk("bounce_one_pulse", (pulse_cnt - base) == 1, 1'b1);
        btn_in = 1'b0;
        wait_n(10);

        // Glitch rejection: three high samples never qualify
        seen = 1'b0;
        btn_in = 1'b1;
        wait_n(3);
        btn_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wait_n(1);
            if (btn_level !== 1'b0 || pulse !== 1'b0) seen = 1'b1;
        end
        chk("glitch_rejected", seen, 1'b0);

        // Async reset right after the press pulse, button kept held
        btn_in = 1'b1;
        wait_n(7);
        chk("pre_reset_pulse", pulse, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_pulse", pulse, 1'b0);
        chk("async_reset_level", btn_level, 1'b0);
        wait_n(2);
        reset = 1'b0;
        wait_n(6);
        chk("post_reset_e5_pulse", pulse, 1'b0);
        wait_n(1);
        chk("post_reset_e6_pulse", pulse, 1'b1);
        chk("post_reset_e6_level", btn_level, 1'b1);
        btn_in = 1'b0;
        wait_n(12);

        // Long hold: pulse edges depend on the auto-repeat build option
        btn_in = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            wait_n(1);
            exp_p = (k == 6);
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
            exp_p = exp_p || (k == 16) || (k == 26) || (k == 36);
`endif
            chk($sformatf("hold_edge%0d_pulse", k), pulse, exp_p);
        end
        btn_in = 1'b0;
        wait_n(12);

        // Randomized dwell times with occasional resets, checked by the model
        for (int i = 0; i < 300; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            dwell = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 35) : $urandom_range(1, 8);
            if ($urandom_range(0, 40) == 0) begin
                #1 reset = 1'b1;
                wait_n(1);
                reset = 1'b0;
            end
            wait_n(dwell);
        end
        btn_in = 1'b0;
        wait_n(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
